// File: rtl/ex_muldiv_ctrl_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide sequencer: start/operands,
// HI/LO move traffic, hazard inputs and the busy/done/stall/HI/LO results.
interface ex_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             hilo_rd;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata, hilo_rd, flush,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata, hilo_rd, flush,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one shift-add or restoring
// divide step per cycle on operand magnitudes, then a single sign-fix cycle.
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  ex_muldiv_ctrl_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rs_raw;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   iter_hi, iter_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operands are only valid during the start cycle, so magnitudes are formed here
  // and captured; op[0] selects signed interpretation.
  assign sign_a = bus.op[0] & bus.rs_val[WIDTH-1];
  assign sign_b = bus.op[0] & bus.rt_val[WIDTH-1];
  assign mag_a  = sign_a ? -bus.rs_val : bus.rs_val;
  assign mag_b  = sign_b ? -bus.rt_val : bus.rt_val;

  // NOTE: state is updated with non-blocking assignments so every always_ff reads
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (count == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Shared iteration datapath: for multiply acc_hi:acc_lo is the partial product
  // with the multiplier in acc_lo; for divide acc_hi is the partial remainder and
  // acc_lo shifts the dividend out while shifting quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_trial = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, operand};
    if (is_div) begin
      if (!div_trial[WIDTH+1]) begin
        iter_hi = div_trial[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // The signed-overflow divide needs no special case: the magnitude quotient is
  // 2^(WIDTH-1), and negating it in WIDTH bits leaves it unchanged.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_res ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
  end

  // NOTE: the datapath registers are few and flop-based, so all of them take the
  // synchronous reset; no value from an aborted operation can leak out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      operand  <= '0;
      rs_raw   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.flush) begin
        unique case (state)
          IDLE: begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
            if (bus.start) begin
              count    <= CNT_W'(WIDTH);
              is_div   <= bus.op[1];
              neg_res  <= sign_a ^ sign_b;
              neg_rem  <= sign_a;
              div_zero <= bus.op[1] & (bus.rt_val == '0);
              rs_raw   <= bus.rs_val;
              acc_hi   <= '0;
              acc_lo   <= bus.op[1] ? mag_a : mag_b;
              operand  <= bus.op[1] ? mag_b : mag_a;
            end
          end
          CALC: begin
            acc_hi <= iter_hi;
            acc_lo <= iter_lo;
            count  <= count - 1'b1;
          end
          FIX: begin
            done_q <= 1'b1;
            if (!is_div) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi_q <= rs_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.hi_we | bus.lo_we);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: a table of mult/div vectors plus hand-written
// sequences for reset, latency, stall hazards, held MTHI, flush and mid-op reset.
module tb_ex_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ex_muldiv_ctrl_if #(.WIDTH(W)) bus ();
  ex_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents the instruction for exactly one cycle, then scrambles the operand
  // buses to prove the block latched them.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    step();
    bus.start  = 1'b0;
    bus.op     = ~op;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      step();
      cycles++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL %s: done not seen within %0d cycles", name, cycles);
    end
  endtask

  initial begin
    int cycles;
    int busy_cnt;
    int n;
    logic ok;
    logic done_seen;

    vecs[0]  = '{"multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"mult_m3x7",   2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"div_m7d2",    2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_100d7",  2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{"divu_5d0",    2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5]  = '{"div_ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{"mult_minsq",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{"multu_shift", 2'b00, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
    vecs[8]  = '{"div_7dm2",    2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{"divu_3d5",    2'b10, 32'd3,         32'd5,         32'd3,         32'd0};
    vecs[10] = '{"div_m8dm3",   2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};
    vecs[11] = '{"div_m5d0",    2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};

    // Reset with a start request pending must leave everything cleared.
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.hilo_rd = 1'b0; bus.flush = 1'b0;
    step(); step(); step();
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_stall", W'(bus.stall), '0);
    bus.start = 1'b0;
    rst = 1'b1;
    step();

    // Latency: busy for 33 observed cycles, done on the 34th.
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0;
    cycles   = 0;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_cnt++;
      step();
      cycles++;
    end
    check("lat_busy_cycles", W'(busy_cnt), 32'd33);
    check("lat_done_edge", W'(cycles), 32'd33);
    check("lat_busy_at_done", W'(bus.busy), '0);
    check("lat_hi", bus.hi, 32'hFFFF_FFFE);
    check("lat_lo", bus.lo, 32'h0000_0001);
    step();
    check("lat_done_pulse", W'(bus.done), '0);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, cycles);
      check({vecs[i].name, "_cyc"}, W'(cycles), 32'd33);
      check({vecs[i].name, "_hi"}, bus.hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.lo, vecs[i].exp_lo);
      step();
    end

    // MFHI/MFLO arriving mid-MULT stalls until the done cycle.
    launch(2'b01, 32'hFFFF_FFFD, 32'd7);
    repeat (4) step();
    bus.hilo_rd = 1'b1;
    #1;
    ok = 1'b1;
    n  = 0;
    while (!bus.done && n < 100) begin
      if (bus.stall !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    check("rd_stall_held", W'(ok), 32'd1);
    check("rd_stall_done", W'(bus.stall), '0);
    check("rd_lo", bus.lo, 32'hFFFF_FFEB);
    bus.hilo_rd = 1'b0;
    step();

    // MTHI while busy is held off and applied once the sequencer is idle.
    launch(2'b00, 32'd2, 32'd3);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    #1;
    ok = 1'b1;
    n  = 0;
    while (!bus.done && n < 100) begin
      if (bus.hi !== 32'hFFFF_FFFF || bus.stall !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    check("mthi_blocked", W'(ok), 32'd1);
    check("mthi_result_hi", bus.hi, 32'd0);
    check("mthi_result_lo", bus.lo, 32'd6);
    check("mthi_stall_idle", W'(bus.stall), '0);
    step();
    bus.hi_we = 1'b0;
    check("mthi_applied", bus.hi, 32'h1234);
    check("mthi_lo_kept", bus.lo, 32'd6);

    // MTHI/MTLO in IDLE, then flush a divide in CALC.
    bus.hi_we = 1'b1; bus.wdata = 32'hAA; step(); bus.hi_we = 1'b0;
    bus.lo_we = 1'b1; bus.wdata = 32'hBB; step(); bus.lo_we = 1'b0;
    check("mt_hi", bus.hi, 32'hAA);
    check("mt_lo", bus.lo, 32'hBB);
    launch(2'b10, 32'd100, 32'd7);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", W'(bus.busy), '0);
    done_seen = bus.done;
    repeat (40) begin
      step();
      if (bus.done) done_seen = 1'b1;
    end
    check("flush_no_done", W'(done_seen), '0);
    check("flush_hi", bus.hi, 32'hAA);
    check("flush_lo", bus.lo, 32'hBB);

    // MTHI together with start: write lands now, result overwrites later.
    bus.hi_we = 1'b1;
    bus.wdata = 32'h55;
    launch(2'b10, 32'd100, 32'd7);
    bus.hi_we = 1'b0;
    check("mthi_start_hi", bus.hi, 32'h55);
    check("mthi_start_busy", W'(bus.busy), 32'd1);
    wait_done("mthi_start", cycles);
    check("mthi_start_res_hi", bus.hi, 32'd2);
    check("mthi_start_res_lo", bus.lo, 32'd14);
    step();

    // Reset mid-CALC discards the operation and clears HI/LO.
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) step();
    rst = 1'b0;
    step();
    check("mid_rst_hi", bus.hi, '0);
    check("mid_rst_lo", bus.lo, '0);
    check("mid_rst_busy", W'(bus.busy), '0);
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.done) done_seen = 1'b1;
    end
    check("mid_rst_no_done", W'(done_seen), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
